approx_adder_pipe: RTL and testbench

Parametrised, pipelined approximate adder with run-time exact/approximate mode select and built-in error statistics. It generalises the fixed 3-bit synthesized approximate adder to WIDTH bits. The lower APPROX_BITS use a lower-part-OR approximation; the upper bits use an exact ripple add. It sits in the accuracy-exploration datapath, where a valid/ready stream of operand pairs is summed and the running error against the exact sum is measured in hardware.

---
 rtl/approx_pkg.sv | 33 +++
 rtl/loa_adder.sv | 28 ++
 rtl/approx_adder_pipe.sv | 116 +++++++++++
 tb/tb_approx_adder_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_pkg.sv
// Shared types and helpers for the approximate adder datapath.
package approx_pkg;

  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_e;

  // Operand fields are sized for the widest supported WIDTH (must be < MAX_W);
  // unused upper bits are constant and trim away.
  localparam int unsigned MAX_W = 64;

  typedef struct packed {
    logic [MAX_W-1:0] a;
    logic [MAX_W-1:0] b;
    logic             cin;
    mode_e            mode;
  } s1_payload_t;

  // acc + inc, clamped to the all-ones value of a w-bit field.
  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] acc,
                                               input logic [MAX_W-1:0] inc,
                                               input int unsigned      w);
    logic [MAX_W:0] one;
    logic [MAX_W:0] sum;
    logic [MAX_W:0] lim;
    one = {{MAX_W{1'b0}}, 1'b1};
    sum = {1'b0, acc} + {1'b0, inc};
    lim = (one << w) - one;
    return (sum > lim) ? lim[MAX_W-1:0] : sum[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/loa_adder.sv
// Lower-part-OR approximate adder: OR on the low APPROX_BITS, exact ripple above.
module loa_adder #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned APPROX_BITS = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);

  generate
    if (APPROX_BITS == 0) begin : g_exact
      assign sum = {1'b0, a} + {1'b0, b};
    end else if (APPROX_BITS >= WIDTH) begin : g_all_or
      assign sum = {a[WIDTH-1] & b[WIDTH-1], a | b};
    end else begin : g_split
      localparam int unsigned L = APPROX_BITS;
      logic             carry;
      logic [WIDTH-L:0] hi;
      // Carry into the exact part is guessed from the top approximated bit only.
      assign carry = a[L-1] & b[L-1];
      assign hi    = {1'b0, a[WIDTH-1:L]} + {1'b0, b[WIDTH-1:L]}
                   + {{(WIDTH-L){1'b0}}, carry};
      assign sum   = {hi, a[L-1:0] | b[L-1:0]};
    end
  endgenerate

endmodule

// File: rtl/approx_adder_pipe.sv
// Two-stage valid/ready approximate adder with exact/approx mode and error statistics.
module approx_adder_pipe
  import approx_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned APPROX_BITS = 3,
  parameter int unsigned ERR_W       = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_mode,
  input  logic             stat_clear,
  output logic [ERR_W-1:0] err_acc,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [WIDTH:0]   err_max
);

  logic             s1_valid;
  s1_payload_t      s1;
  s1_payload_t      s1_next;
  logic             s2_valid;
  logic [WIDTH:0]   s2_approx;
  logic [WIDTH:0]   s2_exact;
  logic             s2_mode;

  logic             s1_load;
  logic             s2_load;
  logic             out_hs;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH:0]   approx_sum;
  logic [WIDTH:0]   exact_sum;
  logic [WIDTH:0]   err;
  logic             unused_hi;

  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;
  assign out_hs   = s2_valid && out_ready;

  always_comb begin
    s1_next                = '0;
    s1_next.a[WIDTH-1:0]   = in_a;
    s1_next.b[WIDTH-1:0]   = in_b;
    s1_next.cin            = in_cin;
    s1_next.mode           = mode_e'(in_mode);
  end

  assign s1_a      = s1.a[WIDTH-1:0];
  assign s1_b      = s1.b[WIDTH-1:0];
  assign unused_hi = ^{s1.a[MAX_W-1:WIDTH], s1.b[MAX_W-1:WIDTH]};
  assign exact_sum = {1'b0, s1_a} + {1'b0, s1_b} + {{WIDTH{1'b0}}, s1.cin};

  loa_adder #(
    .WIDTH      (WIDTH),
    .APPROX_BITS(APPROX_BITS)
  ) u_loa (
    .a  (s1_a),
    .b  (s1_b),
    .sum(approx_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1        <= '0;
      s2_valid  <= 1'b0;
      s2_approx <= '0;
      s2_exact  <= '0;
      s2_mode   <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) s1 <= s1_next;
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          // With no approximated bits the approximate path is the exact sum, cin included.
          s2_approx <= (APPROX_BITS != 0) ? approx_sum : exact_sum;
          s2_exact  <= exact_sum;
          s2_mode   <= s1.mode;
        end
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_mode  = s2_mode;
  assign out_sum   = (s2_mode == MODE_APPROX) ? s2_approx : s2_exact;
  assign err       = (s2_exact >= s2_approx) ? (s2_exact - s2_approx)
                                             : (s2_approx - s2_exact);

  always_ff @(posedge clk) begin
    if (rst || stat_clear) begin
      err_acc    <= '0;
      sample_cnt <= '0;
      err_max    <= '0;
    end else if (out_hs && (s2_mode == MODE_APPROX)) begin
      err_acc    <= ERR_W'(sat_add(MAX_W'(err_acc), MAX_W'(err), ERR_W));
      sample_cnt <= CNT_W'(sat_add(MAX_W'(sample_cnt), MAX_W'(1), CNT_W));
      err_max    <= (err > err_max) ? err : err_max;
    end
  end

endmodule

// File: tb/tb_approx_adder_pipe.sv
// Directed, table-driven self-checking bench for approx_adder_pipe (WIDTH=8, L=3).
module tb_approx_adder_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_cin;
  logic       in_mode;
  logic       out_ready;
  logic       stat_clear;

  logic        in_ready, out_valid, out_mode;
  logic [8:0]  out_sum, err_max;
  logic [15:0] err_acc, sample_cnt;

  logic        s_in_ready, s_out_valid, s_out_mode;
  logic [8:0]  s_out_sum, s_err_max;
  logic [3:0]  s_err_acc;
  logic [15:0] s_sample_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  approx_adder_pipe #(.WIDTH(8), .APPROX_BITS(3), .ERR_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_mode(out_mode), .stat_clear(stat_clear), .err_acc(err_acc),
    .sample_cnt(sample_cnt), .err_max(err_max)
  );

  approx_adder_pipe #(.WIDTH(8), .APPROX_BITS(3), .ERR_W(4), .CNT_W(16)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_mode(in_mode),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_sum(s_out_sum),
    .out_mode(s_out_mode), .stat_clear(stat_clear), .err_acc(s_err_acc),
    .sample_cnt(s_sample_cnt), .err_max(s_err_max)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cin;
    logic        mode;
    logic [8:0]  sum;
    int unsigned err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic mode);
    int unsigned n;
    logic ok;
    in_a = a; in_b = b; in_cin = cin; in_mode = mode; in_valid = 1'b1;
    n = 0; ok = 1'b0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    chk("send_accept", {63'd0, ok}, 64'd1);
  endtask

  task automatic wait_out(output int unsigned lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
  endtask

  function automatic logic [8:0] stream_exp(input int unsigned i);
    logic [7:0] a, b;
    a = 8'(i * 37 + 5);
    b = 8'(i * 11 + 200);
    return {1'b0, a} + {1'b0, b} + 9'(i % 2);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lat, exp_acc, exp_cnt, exp_max;
    int unsigned sent, delivered, inflight, cyc;

    vecs[0] = '{8'h07, 8'h01, 1'b0, 1'b1, 9'h007, 1};
    vecs[1] = '{8'h0C, 8'h04, 1'b0, 1'b1, 9'h014, 4};
    vecs[2] = '{8'hFF, 8'h01, 1'b1, 1'b1, 9'h0FF, 2};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF, 0};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 1'b1, 9'h000, 0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 9'h1FF, 1};
    vecs[6] = '{8'h12, 8'h34, 1'b1, 1'b0, 9'h047, 0};
    vecs[7] = '{8'h05, 8'h02, 1'b1, 1'b1, 9'h007, 1};
    vecs[8] = '{8'h80, 8'h80, 1'b0, 1'b1, 9'h100, 0};
    vecs[9] = '{8'h04, 8'h04, 1'b0, 1'b1, 9'h00C, 4};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    in_mode = 1'b0; out_ready = 1'b1; stat_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_mode", out_mode, 0);
    chk("rst_err_acc", err_acc, 0);
    chk("rst_sample_cnt", sample_cnt, 0);
    chk("rst_err_max", err_max, 0);
    @(posedge clk); #1;

    exp_acc = 0; exp_cnt = 0; exp_max = 0;
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].mode);
      wait_out(lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 2);
      chk($sformatf("vec%0d_sum", i), out_sum, vecs[i].sum);
      chk($sformatf("vec%0d_mode", i), out_mode, vecs[i].mode);
      if (vecs[i].mode) begin
        exp_acc += vecs[i].err;
        exp_cnt++;
        if (vecs[i].err > exp_max) exp_max = vecs[i].err;
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("vec%0d_err_acc", i), err_acc, 64'(exp_acc));
      chk($sformatf("vec%0d_sample_cnt", i), sample_cnt, 64'(exp_cnt));
      chk($sformatf("vec%0d_err_max", i), err_max, 64'(exp_max));
      @(posedge clk); #1;
    end

    // Exact-mode stream under toggling backpressure.
    sent = 0; delivered = 0; inflight = 0; cyc = 0;
    while (delivered < 10 && cyc < 200) begin
      out_ready = ((cyc % 4) < 2);
      if (sent < 10) begin
        in_valid = 1'b1;
        in_a = 8'(sent * 37 + 5);
        in_b = 8'(sent * 11 + 200);
        in_cin = sent[0];
        in_mode = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk("stream_in_ready", in_ready, {63'd0, !(inflight == 2 && !out_ready)});
      if (out_valid && out_ready) begin
        chk($sformatf("stream%0d_sum", delivered), out_sum, stream_exp(delivered));
        chk("stream_mode", out_mode, 0);
        delivered++;
        inflight--;
      end
      if (in_valid && in_ready) begin
        sent++;
        inflight++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_delivered", 64'(delivered), 10);
    repeat (3) begin
      @(negedge clk);
      chk("stream_no_extra", out_valid, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("stream_err_acc", err_acc, 64'(exp_acc));
    chk("stream_sample_cnt", sample_cnt, 64'(exp_cnt));
    chk("stream_err_max", err_max, 64'(exp_max));
    @(posedge clk); #1;

    stat_clear = 1'b1;
    @(posedge clk); #1;
    stat_clear = 1'b0;
    @(negedge clk);
    chk("clear_err_acc", err_acc, 0);
    chk("clear_sample_cnt", sample_cnt, 0);
    chk("clear_err_max", err_max, 0);
    chk("clear_sat_err_acc", s_err_acc, 0);
    @(posedge clk); #1;

    // Five err=4 samples: 4-bit accumulator clamps at 15, 16-bit reaches 20.
    repeat (5) send(8'h0C, 8'h04, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("sat_err_acc", s_err_acc, 15);
    chk("sat_sample_cnt", s_sample_cnt, 5);
    chk("sat_err_max", s_err_max, 4);
    chk("wide_err_acc", err_acc, 20);
    chk("wide_sample_cnt", sample_cnt, 5);
    @(posedge clk); #1;

    send(8'h0C, 8'h04, 1'b0, 1'b1);
    @(posedge clk); #1;
    stat_clear = 1'b1;
    @(negedge clk);
    chk("clear_hs_valid", out_valid, 1);
    @(posedge clk); #1;
    stat_clear = 1'b0;
    @(negedge clk);
    chk("clear_hs_err_acc", err_acc, 0);
    chk("clear_hs_sample_cnt", sample_cnt, 0);
    chk("clear_hs_err_max", err_max, 0);
    chk("clear_hs_sat_err_acc", s_err_acc, 0);
    chk("clear_hs_out_valid", out_valid, 0);
    @(posedge clk); #1;

    // Build up stats, then hold two beats and reset with them in flight.
    send(8'h04, 8'h04, 1'b0, 1'b1);
    wait_out(lat);
    chk("pre_rst_sum", out_sum, 9'h00C);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_err_acc", err_acc, 4);
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(8'h0C, 8'h04, 1'b0, 1'b1);
    send(8'h07, 8'h01, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_out_sum", out_sum, 9'h014);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_sum", out_sum, 0);
    chk("mid_rst_out_mode", out_mode, 0);
    chk("mid_rst_err_acc", err_acc, 0);
    chk("mid_rst_sample_cnt", sample_cnt, 0);
    chk("mid_rst_err_max", err_max, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_stale", out_valid, 0);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
